sfu_acc_bank: RTL

Parametrised successor to the single-register SFU. It holds a per-column bank of `depth` signed accumulators, addressed by output row, so several output rows can be accumulated in an interleaved order. Reads are pipelined, with selectable pass-through or ReLU activation. A per-column running-max tracker reports the largest post-activation value and its row address, for furthest-distance selection downstream. It sits between the array's psum outputs and the output SRAM / top-k logic.

---
 rtl/sfu_acc_bank.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sfu_acc_bank.sv
// sfu_acc_bank: per-column bank of signed saturating accumulators addressed by
// output row, with a pipelined read port (pass-through or ReLU) and a
// per-column running-max tracker that reports the winning value and row.
module sfu_acc_bank #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_i,
    input  logic                     acc_first_i,
    input  logic [addr_bw-1:0]       acc_addr,
    input  logic [psum_bw*col-1:0]   psum_in,
    input  logic                     rd_i,
    input  logic [addr_bw-1:0]       rd_addr,
    input  logic                     relu_i,
    input  logic                     max_clr_i,
    output logic [psum_bw*col-1:0]   psum_out,
    output logic                     out_valid,
    output logic [psum_bw*col-1:0]   max_out,
    output logic [addr_bw*col-1:0]   max_idx,
    output logic [col-1:0]           sat_flag
);

    localparam int DEPTH = 1 << addr_bw;
    localparam logic [psum_bw-1:0] MAX_POS = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] MIN_NEG = {1'b1, {(psum_bw-1){1'b0}}};

    logic [psum_bw-1:0]     mem_q [DEPTH][col];
    logic [psum_bw-1:0]     mem_d [DEPTH][col];
    logic [col-1:0]         sat_q, sat_d;
    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   valid_q, valid_d;
    logic [addr_bw-1:0]     raddr_q, raddr_d;
    logic [psum_bw*col-1:0] max_q, max_d;
    logic [addr_bw*col-1:0] idx_q, idx_d;

    // Signed add in psum_bw+1 bits; MSB of the result flags a clamp.
    function automatic logic [psum_bw:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1]) begin
            sat_add = {1'b1, (s[psum_bw] ? MIN_NEG : MAX_POS)};
        end else begin
            sat_add = {1'b0, s[psum_bw-1:0]};
        end
    endfunction

    // Accumulate path: load or saturating add into the addressed row.
    always_comb begin
        logic [psum_bw:0] res;
        mem_d = mem_q;
        sat_d = sat_q;
        res   = '0;
        if (acc_i) begin
            for (int c = 0; c < col; c++) begin
                if (acc_first_i) begin
                    mem_d[acc_addr][c] = psum_in[c*psum_bw +: psum_bw];
                end else begin
                    res = sat_add(mem_q[acc_addr][c], psum_in[c*psum_bw +: psum_bw]);
                    mem_d[acc_addr][c] = res[psum_bw-1:0];
                    if (res[psum_bw]) begin
                        sat_d[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Read path: old bank contents (read-before-write), optional ReLU.
    always_comb begin
        logic [psum_bw-1:0] v;
        out_d   = out_q;
        raddr_d = raddr_q;
        valid_d = rd_i;
        v       = '0;
        if (rd_i) begin
            raddr_d = rd_addr;
            for (int c = 0; c < col; c++) begin
                v = mem_q[rd_addr][c];
                out_d[c*psum_bw +: psum_bw] = (relu_i && v[psum_bw-1]) ? '0 : v;
            end
        end
    end

    // Max tracker: strict greater-than keeps the earlier row on ties; clear wins.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (max_clr_i) begin
            max_d = {col{MIN_NEG}};
            idx_d = '0;
        end else if (valid_q) begin
            for (int c = 0; c < col; c++) begin
                if ($signed(out_q[c*psum_bw +: psum_bw]) > $signed(max_q[c*psum_bw +: psum_bw])) begin
                    max_d[c*psum_bw +: psum_bw] = out_q[c*psum_bw +: psum_bw];
                    idx_d[c*addr_bw +: addr_bw] = raddr_q;
                end
            end
        end
    end

    // Bank storage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int c = 0; c < col; c++) begin
                    mem_q[i][c] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read pipeline, tracker and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            raddr_q <= '0;
            max_q   <= {col{MIN_NEG}};
            idx_q   <= '0;
        end else begin
            sat_q   <= sat_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            raddr_q <= raddr_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

    assign psum_out  = out_q;
    assign out_valid = valid_q;
    assign max_out   = max_q;
    assign max_idx   = idx_q;
    assign sat_flag  = sat_q;

endmodule
